// File: rtl/csr_regfile_pkg.sv
// Shared CSR definitions: addresses, mstatus/mie/mip bit positions, mcause codes.
package csr_regfile_pkg;

  // Implemented machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mie / mip timer-interrupt bit
  localparam int MIE_MTIE = 7;
  localparam int MIP_MTIP = 7;

  // mtvec modes that are legal to store
  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Machine timer interrupt cause code
  localparam logic [63:0] MCAUSE_MTI = {1'b1, 63'd7};

  // True for every address this register file implements
  function automatic logic csr_is_impl(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID: csr_is_impl = 1'b1;
      default:                                                    csr_is_impl = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running XLEN-wide counter; a load in the same cycle replaces the increment.
module csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  // Load wins over increment; natural wrap from all-ones to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational read port, write-back commit, trap entry,
// mret, mcycle/minstret counting and the timer interrupt request.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_raddr_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic [11:0]     csr_waddr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            csr_wvalid_i,
  input  logic            retire_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic            mret_i,
  input  logic            mtip_i,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending_o
);

  localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);

  // Architectural state (only the writable mstatus/mie/mip bits are stored)
  logic            mie_q;
  logic            mpie_q;
  logic            mtie_q;
  logic            mtip_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  // A trap or mret owns mstatus/mepc/mcause for the cycle; software writes to them are dropped
  logic event_cycle;
  logic wr_shared;
  assign event_cycle = trap_valid_i | mret_i;
  assign wr_shared   = csr_wvalid_i & ~event_cycle;

  logic mcycle_load;
  logic minstret_load;
  assign mcycle_load   = csr_wvalid_i && (csr_waddr_i == CSR_MCYCLE);
  assign minstret_load = csr_wvalid_i && (csr_waddr_i == CSR_MINSTRET);

  csr_counter #(.W(XLEN)) u_mcycle (
    .clk      (clk),
    .rst      (rst),
    .inc      (1'b1),
    .load     (mcycle_load),
    .load_val (csr_wdata_i),
    .count    (mcycle)
  );

  csr_counter #(.W(XLEN)) u_minstret (
    .clk      (clk),
    .rst      (rst),
    .inc      (retire_i),
    .load     (minstret_load),
    .load_val (csr_wdata_i),
    .count    (minstret)
  );

  // Trap/mret-controlled state: trap > mret > software write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap_valid_i) begin
      mepc_q   <= trap_pc_i & LOW2_MASK;
      mcause_q <= trap_cause_i;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (mret_i) begin
      mie_q    <= mpie_q;
      mpie_q   <= 1'b1;
    end else if (wr_shared) begin
      case (csr_waddr_i)
        CSR_MSTATUS: begin
          mie_q  <= csr_wdata_i[MSTATUS_MIE];
          mpie_q <= csr_wdata_i[MSTATUS_MPIE];
        end
        CSR_MEPC:   mepc_q   <= csr_wdata_i & LOW2_MASK;
        CSR_MCAUSE: mcause_q <= csr_wdata_i;
        default: ;
      endcase
    end
  end

  // Software-only state plus the registered timer line; unaffected by trap/mret
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtie_q     <= 1'b0;
      mtip_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
    end else begin
      mtip_q <= mtip_i;
      if (csr_wvalid_i) begin
        case (csr_waddr_i)
          CSR_MIE:      mtie_q <= csr_wdata_i[MIE_MTIE];
          CSR_MSCRATCH: mscratch_q <= csr_wdata_i;
          CSR_MTVEC: begin
            mtvec_q[XLEN-1:2] <= csr_wdata_i[XLEN-1:2];
            if (csr_wdata_i[1:0] == MTVEC_DIRECT || csr_wdata_i[1:0] == MTVEC_VECTORED)
              mtvec_q[1:0] <= csr_wdata_i[1:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Read mux; unimplemented addresses return zero and flag illegal
  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = ~csr_is_impl(csr_raddr_i);
    case (csr_raddr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        csr_rdata_o[MSTATUS_MPIE]                  = mpie_q;
        csr_rdata_o[MSTATUS_MIE]                   = mie_q;
      end
      CSR_MIE:      csr_rdata_o[MIE_MTIE] = mtie_q;
      CSR_MTVEC:    csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: csr_rdata_o = mscratch_q;
      CSR_MEPC:     csr_rdata_o = mepc_q;
      CSR_MCAUSE:   csr_rdata_o = mcause_q;
      CSR_MIP:      csr_rdata_o[MIP_MTIP] = mtip_q;
      CSR_MCYCLE:   csr_rdata_o = mcycle;
      CSR_MINSTRET: csr_rdata_o = minstret;
      default: ;
    endcase
  end

  // Trap target: vectored mode offsets interrupts by 4*cause code, exceptions go to base
  always_comb begin
    trap_vec_o = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[1:0] == MTVEC_VECTORED && trap_cause_i[XLEN-1])
      trap_vec_o = {mtvec_q[XLEN-1:2], 2'b00} + {trap_cause_i[XLEN-3:0], 2'b00};
  end

  assign mepc_o        = mepc_q;
  assign irq_pending_o = mie_q & mtie_q & mtip_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios followed by randomized traffic,
// all compared against an architectural model of the CSR file.
module tb_csr_regfile;
  import csr_regfile_pkg::*;

  localparam int          XLEN      = 64;
  localparam logic [63:0] MTVEC_RST = 64'h0;
  localparam logic [63:0] INT_BIT   = 64'h8000_0000_0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_raddr_i;
  logic [63:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic [11:0] csr_waddr_i;
  logic [63:0] csr_wdata_i;
  logic        csr_wvalid_i;
  logic        retire_i;
  logic        trap_valid_i;
  logic [63:0] trap_pc_i;
  logic [63:0] trap_cause_i;
  logic        mret_i;
  logic        mtip_i;
  logic [63:0] trap_vec_o;
  logic [63:0] mepc_o;
  logic        irq_pending_o;

  always #5 clk = ~clk;

  csr_regfile #(.XLEN(XLEN), .MTVEC_RST(MTVEC_RST)) dut (
    .clk           (clk),
    .rst           (rst),
    .csr_raddr_i   (csr_raddr_i),
    .csr_rdata_o   (csr_rdata_o),
    .csr_illegal_o (csr_illegal_o),
    .csr_waddr_i   (csr_waddr_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_wvalid_i  (csr_wvalid_i),
    .retire_i      (retire_i),
    .trap_valid_i  (trap_valid_i),
    .trap_pc_i     (trap_pc_i),
    .trap_cause_i  (trap_cause_i),
    .mret_i        (mret_i),
    .mtip_i        (mtip_i),
    .trap_vec_o    (trap_vec_o),
    .mepc_o        (mepc_o),
    .irq_pending_o (irq_pending_o)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model: architectural CSR values ----------------
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [63:0] m_mcycle, m_minstret;
  logic [11:0] addr_tab [0:12];

  task automatic model_reset();
    m_mstatus  = 64'h1800;
    m_mie      = 64'h0;
    m_mtvec    = MTVEC_RST;
    m_mscratch = 64'h0;
    m_mepc     = 64'h0;
    m_mcause   = 64'h0;
    m_mip      = 64'h0;
    m_mcycle   = 64'h0;
    m_minstret = 64'h0;
  endtask

  task automatic model_read(input logic [11:0] a, output logic [63:0] v, output logic ill);
    ill = 1'b0;
    case (a)
      12'h300: v = m_mstatus;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: v = m_mip;
      12'hB00: v = m_mcycle;
      12'hB02: v = m_minstret;
      12'hF14: v = 64'h0;
      default: begin v = 64'h0; ill = 1'b1; end
    endcase
  endtask

  // Apply one rising edge worth of architectural effects from the current inputs
  task automatic model_edge();
    logic [63:0] ms, mepc_n, mcause_n, mcyc_n, mins_n;
    logic        blocked;
    blocked  = trap_valid_i || mret_i;
    ms       = m_mstatus;
    mepc_n   = m_mepc;
    mcause_n = m_mcause;
    mcyc_n   = m_mcycle + 64'd1;
    mins_n   = m_minstret + (retire_i ? 64'd1 : 64'd0);
    if (csr_wvalid_i) begin
      case (csr_waddr_i)
        12'h300: if (!blocked) ms = (m_mstatus & ~64'h88) | (csr_wdata_i & 64'h88);
        12'h304: m_mie = csr_wdata_i & 64'h80;
        12'h305: m_mtvec = (csr_wdata_i[1:0] < 2'd2) ? csr_wdata_i
                                                   : ((csr_wdata_i & ~64'h3) | (m_mtvec & 64'h3));
        12'h340: m_mscratch = csr_wdata_i;
        12'h341: if (!blocked) mepc_n = csr_wdata_i & ~64'h3;
        12'h342: if (!blocked) mcause_n = csr_wdata_i;
        12'hB00: mcyc_n = csr_wdata_i;
        12'hB02: mins_n = csr_wdata_i;
        default: ;
      endcase
    end
    if (trap_valid_i) begin
      mepc_n   = trap_pc_i & ~64'h3;
      mcause_n = trap_cause_i;
      ms[7]    = m_mstatus[3];
      ms[3]    = 1'b0;
    end else if (mret_i) begin
      ms[3] = m_mstatus[7];
      ms[7] = 1'b1;
    end
    m_mstatus  = ms;
    m_mepc     = mepc_n;
    m_mcause   = mcause_n;
    m_mcycle   = mcyc_n;
    m_minstret = mins_n;
    m_mip      = mtip_i ? 64'h80 : 64'h0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] ev, base, tv;
    logic        ei;
    model_read(csr_raddr_i, ev, ei);
    check("rdata", csr_rdata_o, ev);
    check("illegal", 64'(csr_illegal_o), 64'(ei));
    base = m_mtvec & ~64'h3;
    if (m_mtvec[1:0] == 2'd1 && trap_cause_i[63])
      tv = base + 64'd4 * (trap_cause_i & ~INT_BIT);
    else
      tv = base;
    check("trap_vec", trap_vec_o, tv);
    check("mepc_o", mepc_o, m_mepc);
    check("irq_pending", 64'(irq_pending_o), 64'(m_mstatus[3] & m_mie[7] & m_mip[7]));
  endtask

  // ---------------- driver ----------------
  // Inputs are set by the caller; outputs checked at the falling edge, model stepped at the rising edge
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    csr_wvalid_i = 1'b0;
    trap_valid_i = 1'b0;
    mret_i       = 1'b0;
    retire_i     = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    csr_wvalid_i = 1'b1;
    csr_waddr_i  = a;
    csr_wdata_i  = d;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    csr_raddr_i = CSR_MCYCLE;
    #1 check("rst_mcycle", csr_rdata_o, 64'h0);
    csr_raddr_i = CSR_MINSTRET;
    #1 check("rst_minstret", csr_rdata_o, 64'h0);
    csr_raddr_i = CSR_MSTATUS;
    #1 check("rst_mstatus", csr_rdata_o, 64'h1800);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    addr_tab[0]  = CSR_MSTATUS;  addr_tab[1]  = CSR_MIE;      addr_tab[2]  = CSR_MTVEC;
    addr_tab[3]  = CSR_MSCRATCH; addr_tab[4]  = CSR_MEPC;     addr_tab[5]  = CSR_MCAUSE;
    addr_tab[6]  = CSR_MIP;      addr_tab[7]  = CSR_MCYCLE;   addr_tab[8]  = CSR_MINSTRET;
    addr_tab[9]  = CSR_MHARTID;  addr_tab[10] = 12'h301;      addr_tab[11] = 12'hB01;
    addr_tab[12] = 12'h7C0;

    rst = 1'b1;
    csr_raddr_i = CSR_MSTATUS; csr_waddr_i = 12'h0; csr_wdata_i = 64'h0; csr_wvalid_i = 1'b0;
    retire_i = 1'b0; trap_valid_i = 1'b0; trap_pc_i = 64'h0; trap_cause_i = 64'h0;
    mret_i = 1'b0; mtip_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1. reset values and mcycle counting from zero
    #1 check("mstatus_rst", csr_rdata_o, 64'h1800);
    check("irq_rst", 64'(irq_pending_o), 64'h0);
    check("trap_vec_rst", trap_vec_o, MTVEC_RST);
    check("mepc_rst", mepc_o, 64'h0);
    csr_raddr_i = CSR_MTVEC;
    #1 check("mtvec_rst", csr_rdata_o, MTVEC_RST);
    csr_raddr_i = CSR_MCYCLE;
    #1 check("mcycle_0", csr_rdata_o, 64'h0);
    step();
    check("mcycle_1", csr_rdata_o, 64'h1);
    step();
    check("mcycle_2", csr_rdata_o, 64'h2);
    csr_raddr_i = 12'h301;
    #1 check("illegal_flag", 64'(csr_illegal_o), 64'h1);
    check("illegal_data", csr_rdata_o, 64'h0);

    // 2. vectored mtvec, interrupt trap target, illegal MODE keeps old MODE
    wr(CSR_MTVEC, 64'h8000_0001);
    step();
    trap_valid_i = 1'b1; trap_cause_i = MCAUSE_MTI; trap_pc_i = 64'h100;
    #1 check("trap_vec_vectored", trap_vec_o, 64'h8000_001C);
    step();
    trap_cause_i = 64'h0;
    wr(CSR_MTVEC, 64'h8000_0003);
    step();
    csr_raddr_i = CSR_MTVEC;
    #1 check("mtvec_mode_kept", csr_rdata_o, 64'h8000_0001);

    // 3. trap then mret stack MIE/MPIE
    wr(CSR_MSTATUS, 64'h8);
    step();
    trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0102; trap_cause_i = 64'd11;
    step();
    csr_raddr_i = CSR_MSTATUS;
    #1 check("trap_mstatus", csr_rdata_o, 64'h1880);
    check("trap_mepc", mepc_o, 64'h8000_0100);
    mret_i = 1'b1;
    step();
    check("mret_mstatus", csr_rdata_o, 64'h1888);

    // 4. trap + mret + mepc write in one cycle: only the trap lands
    trap_valid_i = 1'b1; mret_i = 1'b1; trap_pc_i = 64'h4000_0006;
    wr(CSR_MEPC, 64'h1234);
    step();
    csr_raddr_i = CSR_MEPC;
    #1 check("combo_mepc", csr_rdata_o, 64'h4000_0004);
    csr_raddr_i = CSR_MSTATUS;
    #1 check("combo_mstatus", csr_rdata_o, 64'h1880);

    // 5. timer interrupt pending, mip not software writable
    wr(CSR_MIE, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    wr(CSR_MSTATUS, 64'h8);
    step();
    mtip_i = 1'b1;
    step();
    check("irq_set", 64'(irq_pending_o), 64'h1);
    wr(CSR_MIP, 64'h0);
    step();
    csr_raddr_i = CSR_MIP;
    #1 check("mip_ro", csr_rdata_o, 64'h80);
    csr_raddr_i = CSR_MIE;
    #1 check("mie_mask", csr_rdata_o, 64'h80);
    mtip_i = 1'b0;

    // 6. counter wrap, write beats increment, asynchronous reset
    wr(CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    csr_raddr_i = CSR_MCYCLE;
    #1 check("mcycle_max", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("mcycle_wrap", csr_rdata_o, 64'h0);
    wr(CSR_MINSTRET, 64'h5); retire_i = 1'b1;
    step();
    csr_raddr_i = CSR_MINSTRET;
    #1 check("minstret_write_wins", csr_rdata_o, 64'h5);
    retire_i = 1'b1;
    step();
    check("minstret_inc", csr_rdata_o, 64'h6);
    async_reset();

    // 7. randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      csr_raddr_i  = addr_tab[$urandom_range(0, 12)];
      csr_wvalid_i = 1'($urandom_range(0, 1));
      csr_waddr_i  = addr_tab[$urandom_range(0, 12)];
      csr_wdata_i  = {$urandom, $urandom};
      retire_i     = 1'($urandom_range(0, 1));
      trap_valid_i = ($urandom_range(0, 7) == 0);
      mret_i       = ($urandom_range(0, 7) == 0);
      trap_pc_i    = {$urandom, $urandom};
      trap_cause_i = ($urandom_range(0, 1) == 1) ? (INT_BIT | 64'($urandom_range(0, 15)))
                                                 : 64'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) mtip_i = ~mtip_i;
      step();
      if (i == 250) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
